// File: rtl/nios2_mycpu_oci_dct_pkg.sv
// ---------------------------------------------------------------------------
// nios2_mycpu_oci_dct_pkg
// Shared definitions for the OCI data/control trace (DCT) packer:
//   CODE_W / SLOTS / CNT_W  - trace code width, codes per word, fill-count width
//   BUF_W                   - packed word width (CODE_W * SLOTS)
//   dct_state_e             - packer run state (RUN, DRAIN, ENDED)
//   stamp_t                 - 16-bit cycle stamp attached to each word when
//                             DCT_TIMESTAMP_EN is defined
// ---------------------------------------------------------------------------
package nios2_mycpu_oci_dct_pkg;

   localparam int CODE_W = 2;
   localparam int SLOTS  = 15;
   localparam int CNT_W  = 4;
   localparam int BUF_W  = CODE_W * SLOTS;

   // Fill count that marks a full accumulator.
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ENDED = 2'd2
   } dct_state_e;

   typedef logic [15:0] stamp_t;

endpackage : nios2_mycpu_oci_dct_pkg

// File: rtl/nios2_mycpu_oci_dct_outreg.sv
// ---------------------------------------------------------------------------
// nios2_mycpu_oci_dct_outreg
// Single-entry valid/ready holding register for completed trace words.
// Optional macro: DCT_TIMESTAMP_EN (adds the stamp path).
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   load                   - capture data_in/count_in (and stamp_in)
//   data_in, count_in      - word and fill count from the accumulator
//   stamp_in               - cycle stamp (DCT_TIMESTAMP_EN only)
//   ready                  - consumer accepts the held word
//   valid, data, count     - held word towards the trace store
//   stamp                  - held stamp (DCT_TIMESTAMP_EN only)
// ---------------------------------------------------------------------------
module nios2_mycpu_oci_dct_outreg
   import nios2_mycpu_oci_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [BUF_W-1:0] data_in,
   input  logic [CNT_W-1:0] count_in,
`ifdef DCT_TIMESTAMP_EN
   input  stamp_t           stamp_in,
   output stamp_t           stamp,
`endif
   input  logic             ready,
   output logic             valid,
   output logic [BUF_W-1:0] data,
   output logic [CNT_W-1:0] count
);

   // NOTE: all state here is updated with non-blocking assignments so every
   // flop samples the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
         count <= '0;
`ifdef DCT_TIMESTAMP_EN
         stamp <= '0;
`endif
      end else begin
         // A load on the handshake edge replaces the departing word, so valid
         // stays high for a back-to-back transfer.
         if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            count <= count_in;
`ifdef DCT_TIMESTAMP_EN
            stamp <= stamp_in;
`endif
         end else if (ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule : nios2_mycpu_oci_dct_outreg

// File: rtl/nios2_mycpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// nios2_mycpu_oci_dct_packer
// Producer end of the OCI DCT path: shifts 2-bit trace codes into a 30-bit
// accumulator and hands full (or flushed) words to a valid/ready output
// register. Exposes the live accumulator and the end-of-test handshake.
// Optional macro: DCT_TIMESTAMP_EN (free-running 16-bit counter, word_stamp).
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   code_valid/code/code_ready - trace code input handshake
//   flush                   - single-cycle request to emit the partial word
//   test_ending             - end-of-test drain request (level)
//   word_valid/word_data/word_count/word_ready - packed word output
//   word_stamp              - transfer-edge cycle stamp (DCT_TIMESTAMP_EN)
//   dct_buffer, dct_count   - live accumulator contents and fill count
//   test_has_ended          - sticky, drain complete
// ---------------------------------------------------------------------------
module nios2_mycpu_oci_dct_packer
   import nios2_mycpu_oci_dct_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] code,
   output logic              code_ready,
   input  logic              flush,
   input  logic              test_ending,
   output logic              word_valid,
   output logic [BUF_W-1:0]  word_data,
   output logic [CNT_W-1:0]  word_count,
   input  logic              word_ready,
   output logic [BUF_W-1:0]  dct_buffer,
   output logic [CNT_W-1:0]  dct_count,
   output logic              test_has_ended
`ifdef DCT_TIMESTAMP_EN
   ,
   output stamp_t            word_stamp
`endif
);

   dct_state_e       state;
   logic             flush_pend;
   logic             flush_req;
   logic             accept;
   logic             transfer;
   logic             pend_next;
   logic [CNT_W-1:0] cnt_next;

   // A flush acts in the cycle it is raised; flush_pend keeps it alive while
   // the output slot is busy or while draining.
   assign flush_req = flush | flush_pend;
   assign accept    = code_valid & code_ready;
   assign transfer  = ((dct_count == FULL_CNT) | flush_req)
                    & (dct_count != '0)
                    & (!word_valid | word_ready);

   // Next fill count, needed to register code_ready one edge ahead.
   always_comb begin
      cnt_next = dct_count;
      if (transfer) begin
         cnt_next = accept ? CNT_W'(1) : '0;
      end else if (accept) begin
         cnt_next = dct_count + CNT_W'(1);
      end
   end

   // A flush against an empty accumulator is simply dropped.
   always_comb begin
      pend_next = flush_req;
      if (transfer || dct_count == '0) begin
         pend_next = 1'b0;
      end
   end

   // NOTE: the reset branch clears only real control/data flops; there is no
   // memory array here that would need to be left out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= RUN;
         flush_pend     <= 1'b0;
         dct_buffer     <= '0;
         dct_count      <= '0;
         code_ready     <= 1'b0;
         test_has_ended <= 1'b0;
      end else begin
         dct_count <= cnt_next;
         if (transfer) begin
            // A code accepted on the transfer edge starts the new word.
            dct_buffer <= accept ? {{(BUF_W-CODE_W){1'b0}}, code} : '0;
         end else if (accept) begin
            dct_buffer <= {dct_buffer[BUF_W-CODE_W-1:0], code};
         end

         flush_pend <= pend_next;
         code_ready <= 1'b0;

         case (state)
            RUN: begin
               if (test_ending) begin
                  state      <= DRAIN;
                  flush_pend <= 1'b1;
               end else begin
                  code_ready <= (cnt_next != FULL_CNT);
               end
            end
            DRAIN: begin
               if (dct_count == '0 && !word_valid) begin
                  state          <= ENDED;
                  test_has_ended <= 1'b1;
               end
            end
            ENDED: begin
               test_has_ended <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

`ifdef DCT_TIMESTAMP_EN
   stamp_t stamp_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stamp_cnt <= '0;
      end else begin
         stamp_cnt <= stamp_cnt + 16'd1;
      end
   end
`endif

   nios2_mycpu_oci_dct_outreg u_outreg (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (transfer),
      .data_in  (dct_buffer),
      .count_in (dct_count),
`ifdef DCT_TIMESTAMP_EN
      .stamp_in (stamp_cnt),
      .stamp    (word_stamp),
`endif
      .ready    (word_ready),
      .valid    (word_valid),
      .data     (word_data),
      .count    (word_count)
   );

endmodule : nios2_mycpu_oci_dct_packer

// File: tb/tb_nios2_mycpu_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_nios2_mycpu_oci_dct_packer
// Directed bench for the DCT packer. Inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_nios2_mycpu_oci_dct_packer;
   import nios2_mycpu_oci_dct_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              code_valid;
   logic [CODE_W-1:0] code;
   logic              code_ready;
   logic              flush;
   logic              test_ending;
   logic              word_valid;
   logic [BUF_W-1:0]  word_data;
   logic [CNT_W-1:0]  word_count;
   logic              word_ready;
   logic [BUF_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              test_has_ended;
`ifdef DCT_TIMESTAMP_EN
   stamp_t            word_stamp;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nios2_mycpu_oci_dct_packer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .code_valid     (code_valid),
      .code           (code),
      .code_ready     (code_ready),
      .flush          (flush),
      .test_ending    (test_ending),
      .word_valid     (word_valid),
      .word_data      (word_data),
      .word_count     (word_count),
      .word_ready     (word_ready),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_has_ended (test_has_ended)
`ifdef DCT_TIMESTAMP_EN
      ,
      .word_stamp     (word_stamp)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Offer one code from a falling edge until it is taken (bounded wait);
   // returns on the falling edge after the accepting rising edge.
   task automatic push(input logic [1:0] c);
      logic ok;
      ok         = 1'b0;
      code_valid = 1'b1;
      code       = c;
      for (int k = 0; k < 50 && !ok; k++) begin
         if (code_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      code_valid = 1'b0;
      check("push_accepted", {31'd0, ok}, 32'd1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      code_valid  = 1'b0;
      code        = '0;
      flush       = 1'b0;
      test_ending = 1'b0;
      word_ready  = 1'b1;

      // ---- reset state ----
      @(negedge clk);
      check("rst_word_valid", {31'd0, word_valid}, 32'd0);
      check("rst_code_ready", {31'd0, code_ready}, 32'd0);
      check("rst_dct_count", {28'd0, dct_count}, 32'd0);
      check("rst_ended", {31'd0, test_has_ended}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, code_ready}, 32'd1);

      // ---- 15 codes 0,1,2,3,... -> full word ----
      for (int i = 0; i < 15; i++) push(2'(i % 4));
      check("full_code_ready_low", {31'd0, code_ready}, 32'd0);
      check("full_cnt15", {28'd0, dct_count}, 32'd15);
      check("full_valid_not_yet", {31'd0, word_valid}, 32'd0);
      @(negedge clk);
      check("full_valid", {31'd0, word_valid}, 32'd1);
      check("full_count", {28'd0, word_count}, 32'd15);
      check("full_data", {2'd0, word_data}, 32'h06C6C6C6);
      check("full_ready_back", {31'd0, code_ready}, 32'd1);
      check("full_acc_clear", {28'd0, dct_count}, 32'd0);
      @(negedge clk);
      check("full_valid_drop", {31'd0, word_valid}, 32'd0);

      // ---- 5 codes of 3 then flush ----
      for (int i = 0; i < 5; i++) push(2'b11);
      check("p5_buffer", {2'd0, dct_buffer}, 32'h000003FF);
      pulse_flush();
      check("p5_valid", {31'd0, word_valid}, 32'd1);
      check("p5_count", {28'd0, word_count}, 32'd5);
      check("p5_data", {2'd0, word_data}, 32'h000003FF);
      check("p5_acc_clear", {28'd0, dct_count}, 32'd0);
      @(negedge clk);
      check("p5_valid_drop", {31'd0, word_valid}, 32'd0);

      // ---- backpressure: two full words with word_ready low ----
      word_ready = 1'b0;
      for (int i = 0; i < 15; i++) push(2'b01);
      for (int i = 0; i < 15; i++) push(2'b10);
      check("bp_ready_low", {31'd0, code_ready}, 32'd0);
      check("bp_acc_full", {28'd0, dct_count}, 32'd15);
      check("bp_held_valid", {31'd0, word_valid}, 32'd1);
      check("bp_held_data", {2'd0, word_data}, 32'h15555555);
      repeat (2) @(negedge clk);
      check("bp_still_held", {2'd0, word_data}, 32'h15555555);
      check("bp_still_low", {31'd0, code_ready}, 32'd0);
      check("bp_acc_hold", {2'd0, dct_buffer}, 32'h2AAAAAAA);
      word_ready = 1'b1;
      @(negedge clk);
      check("bp_second_valid", {31'd0, word_valid}, 32'd1);
      check("bp_second_data", {2'd0, word_data}, 32'h2AAAAAAA);
      check("bp_second_count", {28'd0, word_count}, 32'd15);
      check("bp_acc_clear", {28'd0, dct_count}, 32'd0);
      @(negedge clk);
      check("bp_valid_drop", {31'd0, word_valid}, 32'd0);

      // ---- flush with empty accumulator ----
      pulse_flush();
      check("ef_no_valid", {31'd0, word_valid}, 32'd0);
      @(negedge clk);
      check("ef_no_valid_2", {31'd0, word_valid}, 32'd0);
      check("ef_cnt0", {28'd0, dct_count}, 32'd0);

      // ---- flush coinciding with a code accept ----
      push(2'b11);
      push(2'b00);
      push(2'b01);
      check("fa_buffer", {2'd0, dct_buffer}, 32'h00000031);
      code_valid = 1'b1;
      code       = 2'b10;
      flush      = 1'b1;
      @(negedge clk);
      code_valid = 1'b0;
      flush      = 1'b0;
      check("fa_valid", {31'd0, word_valid}, 32'd1);
      check("fa_count", {28'd0, word_count}, 32'd3);
      check("fa_data", {2'd0, word_data}, 32'h00000031);
      check("fa_new_cnt", {28'd0, dct_count}, 32'd1);
      check("fa_new_buf", {2'd0, dct_buffer}, 32'h00000002);
      pulse_flush();
      check("fa_b2b_valid", {31'd0, word_valid}, 32'd1);
      check("fa_b2b_count", {28'd0, word_count}, 32'd1);
      check("fa_b2b_data", {2'd0, word_data}, 32'h00000002);
      @(negedge clk);
      check("fa_valid_drop", {31'd0, word_valid}, 32'd0);

      // ---- reset while a word is held and accumulator is partial ----
      word_ready = 1'b0;
      for (int i = 0; i < 15; i++) push(2'b11);
      for (int i = 0; i < 4; i++) push(2'b01);
      check("mr_held", {31'd0, word_valid}, 32'd1);
      check("mr_partial", {28'd0, dct_count}, 32'd4);
      #2 reset_n = 1'b0;
      #1;
      check("mr_valid0", {31'd0, word_valid}, 32'd0);
      check("mr_wcount0", {28'd0, word_count}, 32'd0);
      check("mr_wdata0", {2'd0, word_data}, 32'd0);
      check("mr_cnt0", {28'd0, dct_count}, 32'd0);
      check("mr_buf0", {2'd0, dct_buffer}, 32'd0);
      check("mr_ready0", {31'd0, code_ready}, 32'd0);
      word_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mr_no_word", {31'd0, word_valid}, 32'd0);
      end

      // ---- end-of-test drain ----
      push(2'b01); push(2'b10); push(2'b11); push(2'b00);
      push(2'b01); push(2'b10); push(2'b11);
      check("te_cnt7", {28'd0, dct_count}, 32'd7);
      test_ending = 1'b1;
      @(negedge clk);
      test_ending = 1'b0;
      check("te_ready_low", {31'd0, code_ready}, 32'd0);
      check("te_no_word_yet", {31'd0, word_valid}, 32'd0);
      @(negedge clk);
      check("te_valid", {31'd0, word_valid}, 32'd1);
      check("te_count", {28'd0, word_count}, 32'd7);
      check("te_data", {2'd0, word_data}, 32'h00001B1B);
      check("te_not_ended", {31'd0, test_has_ended}, 32'd0);
      @(negedge clk);
      check("te_valid_drop", {31'd0, word_valid}, 32'd0);
      check("te_not_ended_2", {31'd0, test_has_ended}, 32'd0);
      @(negedge clk);
      check("te_ended", {31'd0, test_has_ended}, 32'd1);
      code_valid = 1'b1;
      code       = 2'b01;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("te_ignored_ready", {31'd0, code_ready}, 32'd0);
         check("te_ignored_cnt", {28'd0, dct_count}, 32'd0);
         check("te_sticky", {31'd0, test_has_ended}, 32'd1);
      end
      code_valid = 1'b0;
      check("te_no_more_words", {31'd0, word_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_nios2_mycpu_oci_dct_packer
